// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
//   Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU. It sits
//   in the EX stage next to the single-cycle ALU. The pipeline stays stalled
//   while busy is high. Each cycle in CALC produces one quotient bit. Divide
//   by zero and signed overflow are resolved when the request is accepted,
//   so those requests skip the iteration.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, accepted only in IDLE when flush is low
//   divOp      00 DIV, 01 DIVU, 10 REM, 11 REMU
//   srcA       dividend, sampled on accept
//   srcB       divisor, sampled on accept
//   flush      abort the current operation, return to IDLE
//   busy       high in CALC and FIX
//   done       one-cycle pulse, divResult valid
//   divResult  quotient or remainder, held until the next result
// ---------------------------------------------------------------------------
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      divOp,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] divResult
);

    localparam int              CW      = $clog2(XLEN);
    localparam logic [CW-1:0]   LASTBIT = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOSTNEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state;
    state_t          nextState;
    logic            nextBusy;
    logic            nextDone;

    logic [XLEN:0]   rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] divisor;
    logic [CW-1:0]   bitCnt;
    logic            isRem;
    logic            negQ;
    logic            negR;

    logic            isSigned;
    logic            accept;
    logic            divByZero;
    logic            overflow;
    logic            special;
    logic [XLEN-1:0] specialResult;
    logic [XLEN-1:0] magA;
    logic [XLEN-1:0] magB;
    logic [XLEN+1:0] trial;
    logic [XLEN-1:0] fixResult;

    assign isSigned  = ~divOp[0];
    assign accept    = (state == IDLE) & start & ~flush;
    assign divByZero = (srcB == '0);
    assign overflow  = isSigned & (srcA == MOSTNEG) & (srcB == '1);
    assign special   = divByZero | overflow;

    // A zero divisor gives all ones for a quotient and the dividend for a remainder.
    // Overflow (most negative / -1) gives the dividend as the quotient and 0 as the remainder.
    always_comb begin
        specialResult = '0;
        if (divByZero) begin
            specialResult = divOp[1] ? srcA : '1;
        end else if (overflow) begin
            specialResult = divOp[1] ? '0 : srcA;
        end
    end

    // Signed operands are turned into magnitudes. MOSTNEG negates to itself, and
    // that value is still correct when read as an unsigned magnitude.
    assign magA = (isSigned & srcA[XLEN-1]) ? -srcA : srcA;
    assign magB = (isSigned & srcB[XLEN-1]) ? -srcB : srcB;

    // The next dividend bit is shifted into the partial remainder and the divisor
    // is subtracted. The extra top bit of trial is the borrow. If it is set, the
    // trial result is dropped and the shifted remainder is kept instead.
    assign trial = {rem, quo[XLEN-1]} - {2'b00, divisor};

    assign fixResult = isRem ? (negR ? -rem[XLEN-1:0] : rem[XLEN-1:0])
                             : (negQ ? -quo : quo);

    // Next-state decode. flush has priority over everything else. busy and done
    // are taken from the next state so that both outputs come straight from flops.
    always_comb begin
        nextState = state;
        nextBusy  = 1'b0;
        nextDone  = 1'b0;
        if (flush) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) nextState = special ? DONE : CALC;
                CALC:    if (bitCnt == LASTBIT) nextState = FIX;
                FIX:     nextState = DONE;
                DONE:    nextState = IDLE;
                default: nextState = IDLE;
            endcase
        end
        nextBusy = (nextState == CALC) | (nextState == FIX);
        nextDone = (nextState == DONE);
    end

    // State register together with the registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= nextState;
            busy  <= nextBusy;
            done  <= nextDone;
        end
    end

    // Datapath. Operands and signs are captured on accept. CALC produces one
    // quotient bit per cycle. FIX applies the result sign and loads divResult.
    // A flush stops any update, so divResult keeps its previous value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem       <= '0;
            quo       <= '0;
            divisor   <= '0;
            bitCnt    <= '0;
            isRem     <= 1'b0;
            negQ      <= 1'b0;
            negR      <= 1'b0;
            divResult <= '0;
        end else if (accept) begin
            isRem   <= divOp[1];
            negQ    <= isSigned & (srcA[XLEN-1] ^ srcB[XLEN-1]);
            negR    <= isSigned & srcA[XLEN-1];
            rem     <= '0;
            quo     <= magA;
            divisor <= magB;
            bitCnt  <= '0;
            if (special) begin
                divResult <= specialResult;
            end
        end else if ((state == CALC) && !flush) begin
            if (trial[XLEN+1]) begin
                rem <= {rem[XLEN-1:0], quo[XLEN-1]};
                quo <= {quo[XLEN-2:0], 1'b0};
            end else begin
                rem <= trial[XLEN:0];
                quo <= {quo[XLEN-2:0], 1'b1};
            end
            bitCnt <= bitCnt + CW'(1);
        end else if ((state == FIX) && !flush) begin
            divResult <= fixResult;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit
//   Self-checking bench for div_unit. The reference model uses plain integer
//   arithmetic for the results and a countdown of stall cycles for the timing.
//   The model is compared with the DUT outputs one time unit after every rising
//   edge. Directed vectors check the results, latencies, flush, ignored starts
//   and asynchronous reset against hand-computed values. A random phase then
//   mixes boundary operands with random operands.
// ---------------------------------------------------------------------------
module tb_div_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            flush = 1'b0;
    logic [1:0]      divOp = 2'b00;
    logic [XLEN-1:0] srcA = '0;
    logic [XLEN-1:0] srcB = '0;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] divResult;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    div_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .divOp     (divOp),
        .srcA      (srcA),
        .srcB      (srcB),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .divResult (divResult)
    );

    always #5 clk = ~clk;

    // Architectural result computed with ordinary integer division.
    function automatic logic [31:0] refResult(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        int sa;
        int sb;
        sa = int'(a);
        sb = int'(b);
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
        case (op)
            2'b00:   return 32'(sa / sb);
            2'b01:   return a / b;
            2'b10:   return 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    function automatic bit isSpecial(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Timing model. A normal op stalls for XLEN+1 cycles and then pulses done.
    // A special case pulses done on the cycle right after it is accepted.
    // flush clears everything except the held result.
    logic        mBusy = 1'b0;
    logic        mDone = 1'b0;
    logic [31:0] mResult = '0;
    logic [31:0] mPending = '0;
    int          mLeft = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mBusy   <= 1'b0;
            mDone   <= 1'b0;
            mResult <= '0;
            mLeft   <= 0;
        end else if (flush) begin
            mBusy <= 1'b0;
            mDone <= 1'b0;
        end else if (mBusy) begin
            if (mLeft == 1) begin
                mBusy   <= 1'b0;
                mDone   <= 1'b1;
                mResult <= mPending;
            end
            mLeft <= mLeft - 1;
        end else if (mDone) begin
            mDone <= 1'b0;
        end else if (start) begin
            if (isSpecial(divOp, srcA, srcB)) begin
                mDone   <= 1'b1;
                mResult <= refResult(divOp, srcA, srcB);
            end else begin
                mBusy    <= 1'b1;
                mLeft    <= XLEN + 1;
                mPending <= refResult(divOp, srcA, srcB);
            end
        end
    end

    // Compare the DUT with the model on every cycle that is out of reset.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            checkOutput("cyc busy", 32'(busy), 32'(mBusy));
            checkOutput("cyc done", 32'(done), 32'(mDone));
            checkOutput("cyc divResult", divResult, mResult);
        end
    end

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        divOp = op;
        srcA  = a;
        srcB  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for done. The wait is bounded so it always ends. The cycle count
    // starts at 1 on the cycle right after the accept edge.
    task automatic waitResult(input string name, input logic [31:0] exp, input int lat,
                              input int startAt);
        int cycles;
        int busyCycles;
        cycles = startAt;
        busyCycles = 0;
        while (!done && cycles < 100) begin
            if (busy) busyCycles++;
            @(negedge clk);
            cycles++;
        end
        checkOutput({name, " latency"}, 32'(cycles), 32'(lat));
        checkOutput({name, " result"}, divResult, exp);
        if (startAt == 1 && lat > 1) checkOutput({name, " busy"}, 32'(busyCycles), 32'(lat - 1));
        @(negedge clk);
    endtask

    task automatic runOp(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
        applyStimulus(op, a, b);
        waitResult(name, exp, lat, 1);
    endtask

    task automatic addVec(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat);
        vec_t v;
        v.op = op;
        v.a = a;
        v.b = b;
        v.exp = exp;
        v.lat = lat;
        vecs.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] pool[8];
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        addVec(2'b00, 32'd20,         32'd3,         32'd6,         34);
        addVec(2'b10, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 34);
        addVec(2'b00, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 34);
        addVec(2'b11, 32'd20,         32'd3,         32'd2,         34);
        addVec(2'b01, 32'hFFFF_FFFF,  32'd2,         32'h7FFF_FFFF, 34);
        addVec(2'b01, 32'd5,          32'd7,         32'd0,         34);
        addVec(2'b11, 32'd5,          32'd7,         32'd5,         34);
        addVec(2'b00, 32'd7,          32'd0,         32'hFFFF_FFFF, 1);
        addVec(2'b10, 32'd7,          32'd0,         32'd7,         1);
        addVec(2'b00, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        addVec(2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);
        addVec(2'b01, 32'd7,          32'd0,         32'hFFFF_FFFF, 1);
        addVec(2'b11, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 34);
        addVec(2'b00, 32'h8000_0000,  32'd1,         32'h8000_0000, 34);
        addVec(2'b10, 32'd7,          32'hFFFF_FFFE, 32'd1,         34);

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset divResult", divResult, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Pin the reference model against the hand-computed values, then run the DUT
        foreach (vecs[i]) begin
            checkOutput($sformatf("model v%0d", i), refResult(vecs[i].op, vecs[i].a, vecs[i].b),
                        vecs[i].exp);
            runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
                  vecs[i].lat);
        end

        // Flush in mid-CALC: no done, previous result kept, next op completes normally
        runOp("div100", 2'b00, 32'd100, 32'd7, 32'd14, 34);
        applyStimulus(2'b00, 32'd1000, 32'd9);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush busy", 32'(busy), 32'd0);
        checkOutput("flush done", 32'(done), 32'd0);
        checkOutput("flush held", divResult, 32'd14);
        repeat (2) @(negedge clk);
        runOp("after flush", 2'b10, 32'd1000, 32'd9, 32'd1, 34);

        // start pulsed while busy is ignored
        applyStimulus(2'b01, 32'd1000, 32'd10);
        repeat (5) @(negedge clk);
        divOp = 2'b00;
        srcA  = 32'd7;
        srcB  = 32'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitResult("busy start", 32'd100, 34, 7);

        // flush beats start in IDLE
        @(negedge clk);
        divOp = 2'b00;
        srcA  = 32'd9;
        srcB  = 32'd0;
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        checkOutput("flush+start busy", 32'(busy), 32'd0);
        checkOutput("flush+start done", 32'(done), 32'd0);
        checkOutput("flush+start held", divResult, 32'd100);

        // start held through DONE is ignored there
        @(negedge clk);
        divOp = 2'b10;
        srcA  = 32'd5;
        srcB  = 32'd0;
        start = 1'b1;
        @(negedge clk);
        checkOutput("special done", 32'(done), 32'd1);
        srcA = 32'd20;
        srcB = 32'd3;
        @(negedge clk);
        start = 1'b0;
        checkOutput("done-start busy", 32'(busy), 32'd0);
        checkOutput("done-start result", divResult, 32'd5);
        @(negedge clk);

        // Asynchronous reset in mid-CALC
        applyStimulus(2'b00, 32'd5000, 32'd3);
        repeat (12) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async busy", 32'(busy), 32'd0);
        checkOutput("async done", 32'(done), 32'd0);
        checkOutput("async divResult", divResult, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Random regression with boundary operands mixed in
        pool[0] = 32'd0;
        pool[1] = 32'd1;
        pool[2] = 32'd2;
        pool[3] = 32'd3;
        pool[4] = 32'h7FFF_FFFF;
        pool[5] = 32'h8000_0000;
        pool[6] = 32'hFFFF_FFFF;
        pool[7] = 32'hFFFF_FFFE;
        for (int n = 0; n < 300; n++) begin
            op = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 7)] : $urandom;
            case ($urandom_range(0, 3))
                0:       b = pool[$urandom_range(0, 7)];
                1:       b = 32'($urandom_range(1, 100));
                default: b = $urandom;
            endcase
            runOp($sformatf("rand%0d", n), op, a, b, refResult(op, a, b),
                  isSpecial(op, a, b) ? 1 : 34);
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
